bus_unpacker: RTL and testbench
===============================

BUS_UNPACKER -- requirements
Module: bus_unpacker

Interface
REQ-001 The module SHALL have parameter LSB_FIRST, default 1: when 1, bytes are taken from a word starting at bits [7:0]; when 0, starting at bits [31:24].
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock, with all logic rising-edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port clear, input, 1 bit: synchronous flush of all buffered data.
REQ-005 The module SHALL have port fifo_dout, input, 32 bits: read data from a standard (non-FWFT) host-to-FPGA FIFO.
REQ-006 The module SHALL have port fifo_empty, input, 1 bit: FIFO empty flag.
REQ-007 The module SHALL have port fifo_rd_en, output, 1 bit: FIFO read strobe.
REQ-008 The module SHALL have port dout_valid, output, 1 bit: a byte is presented.
REQ-009 The module SHALL have port dout_ready, input, 1 bit: the consumer accepts the presented byte.
REQ-010 The module SHALL have port din_out, output, 6 bits: byte bits [7:2].
REQ-011 The module SHALL have port d1_out, output, 1 bit: byte bit [1].
REQ-012 The module SHALL have port d0_out, output, 1 bit: byte bit [0].
REQ-013 The module SHALL have port word_last, output, 1 bit: high with the 4th byte of each word.

Function
REQ-014 The module SHALL treat FIFO read data as valid on the cycle after fifo_rd_en is high and fifo_empty is low, and never as valid otherwise.
REQ-015 The module SHALL assert fifo_rd_en only when fifo_empty is low, clear is low, and fewer than 2 words are held plus in flight.
REQ-016 The module SHALL hold words in a 2-entry buffer: the current word being split and one pending word.
REQ-017 The module SHALL split each word into 4 bytes, in order 0,1,2,3 (LSB_FIRST=1) or 3,2,1,0 (LSB_FIRST=0).
REQ-018 The module SHALL unpack each byte B as din_out=B[7:2], d1_out=B[1], d0_out=B[0], the exact inverse of the capture-side {din,d1,d0} packing.
REQ-019 All outputs SHALL be registered.
REQ-020 A byte SHALL transfer when dout_valid and dout_ready are both high on the same edge.
REQ-021 While dout_valid is high and dout_ready is low, din_out, d1_out, d0_out and word_last SHALL be held stable.
REQ-022 dout_valid SHALL NOT fall without a transfer, except on clear or reset.
REQ-023 Latency SHALL be exactly 2 cycles from the first rd_en edge to dout_valid, given that the module is empty and dout_ready is high.
REQ-024 Sustained throughput SHALL be 1 byte per cycle, with no bubble at word boundaries, whenever the FIFO stays non-empty and dout_ready stays high.
REQ-025 The byte index SHALL wrap from 3 to 0 on transfer of a word_last byte.
REQ-026 On that wrap, the pending word SHALL become the current word in the same cycle.
REQ-027 A word arriving in the cycle the current word retires SHALL be stored without loss or reordering.
REQ-028 When the buffer is empty, dout_valid SHALL be low.
REQ-029 The module SHALL NOT issue rd_en speculatively.
REQ-030 A clear SHALL, on the next edge, drop dout_valid and empty both buffer entries.
REQ-031 A clear SHALL also discard any FIFO word returning in the cycle after the clear.
REQ-032 clear SHALL take priority over a simultaneous transfer and over a simultaneous read return.

Reset
REQ-033 While rst_n is low, fifo_rd_en, dout_valid, din_out, d1_out, d0_out and word_last SHALL be 0.
REQ-034 While rst_n is low, the byte index SHALL be 0 and both buffer entries SHALL be empty.
REQ-035 Reset SHALL take effect asynchronously, mid-word included.
REQ-036 Reset SHALL be released synchronously to clk by the system.
REQ-037 An outstanding FIFO read at reset assertion SHALL be discarded.

Structure
REQ-038 A shared package SHALL hold BYTES_PER_WORD=4, WORD_W=32, BYTE_W=8, and the field positions DIN_MSB=7, DIN_LSB=2, D1_BIT=1, D0_BIT=0.
REQ-039 The capture-side packer SHALL use the same package constants as this module.
REQ-040 The 2-entry word buffer, with its in-flight accounting, SHALL be one sub-module named word_buf2.
REQ-041 Byte selection and the output register SHALL reside in bus_unpacker.

Verification
REQ-042 Single word: FIFO holds 0xFFAA5503, LSB_FIRST=1, ready held 1 -> bytes 0x03,0x55,0xAA,0xFF appear on cycles 2..5 after rd_en; the first has din_out=0x00, d1=1, d0=1; the last has din_out=0x3F, d1=1, d0=1; word_last is high only on 0xFF.
REQ-043 Streaming: 8 words back-to-back, ready=1 -> 32 consecutive valid cycles with no gap, and rd_en never high with empty=1.
REQ-044 Backpressure: ready low for 5 cycles during byte 2 -> outputs frozen, rd_en stops after 2 words are held, and the sequence resumes intact.
REQ-045 Clear collision: clear asserted the cycle after rd_en -> the returning word is dropped, dout_valid=0 next cycle, and the next word starts at byte 0.
REQ-046 Async reset mid-word: rst_n low between edges -> all outputs 0 immediately, and after release the first byte is byte 0 of a fresh word.
REQ-047 LSB_FIRST=0 with 0x11223344 -> bytes 0x11,0x22,0x33,0x44 are emitted, with word_last on 0x44.

Source files
------------

// File: rtl/bus_unpacker_pkg.sv
// Shared definitions for the host-to-FPGA byte path.
//
// Holds the word/byte geometry and the bit positions of the {din, d1, d0}
// fields inside one byte. The capture-side packer and this unpacker both
// build on these constants and helpers, so the two ends cannot drift apart.
//
// Contents:
//   BYTES_PER_WORD, WORD_W, BYTE_W      word and byte geometry
//   DIN_MSB, DIN_LSB, D1_BIT, D0_BIT    field positions inside a byte
//   byte_fields_t                       a byte viewed as its three fields
//   select_byte()                       pick byte lane idx of a word
//   unpack_byte() / pack_byte()         byte <-> fields, exact inverses
package bus_unpacker_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;
    localparam int BYTE_W         = 8;

    localparam int DIN_MSB = 7;
    localparam int DIN_LSB = 2;
    localparam int D1_BIT  = 1;
    localparam int D0_BIT  = 0;

    localparam int DIN_W = DIN_MSB - DIN_LSB + 1;
    localparam int IDX_W = $clog2(BYTES_PER_WORD);

    typedef logic [IDX_W-1:0]  byte_idx_t;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [BYTE_W-1:0] byte_t;

    typedef struct packed {
        logic [DIN_W-1:0] din;
        logic             d1;
        logic             d0;
    } byte_fields_t;

    localparam byte_idx_t LAST_IDX = byte_idx_t'(BYTES_PER_WORD - 1);

    // Emission order idx counts 0..3; in MSB-first mode lane 3 goes out first.
    function automatic byte_t select_byte(input word_t w, input byte_idx_t idx,
                                          input bit lsb_first);
        byte_idx_t lane;
        lane = lsb_first ? idx : byte_idx_t'(LAST_IDX - idx);
        return w[int'(lane)*BYTE_W +: BYTE_W];
    endfunction

    function automatic byte_fields_t unpack_byte(input byte_t b);
        byte_fields_t f;
        f.din = b[DIN_MSB:DIN_LSB];
        f.d1  = b[D1_BIT];
        f.d0  = b[D0_BIT];
        return f;
    endfunction

    function automatic byte_t pack_byte(input logic [DIN_W-1:0] din,
                                        input logic d1, input logic d0);
        byte_t b;
        b                  = '0;
        b[DIN_MSB:DIN_LSB] = din;
        b[D1_BIT]          = d1;
        b[D0_BIT]          = d0;
        return b;
    endfunction

endpackage

// File: rtl/word_buf2.sv
// Two-entry word buffer in front of a standard (non-FWFT) FIFO.
//
// Entry "cur" is the word being split into bytes, entry "pend" is the next
// one. A read is only issued when the held words plus the one in flight
// leave room, so every returning word has a slot and no read is speculative.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clear           synchronous flush; also drops a word returning this cycle
//   fifo_dout       FIFO read data, valid the cycle after a granted read
//   fifo_empty      FIFO empty flag
//   fifo_rd_en      FIFO read strobe
//   pop             consumer has taken the last byte of cur
//   cur_valid       cur holds a word
//   cur_word        the word being split
module word_buf2
    import bus_unpacker_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [WORD_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic              pop,
    output logic              cur_valid,
    output logic [WORD_W-1:0] cur_word
);

    logic        pend_valid;
    word_t       pend_word;
    logic        rd_pending;   // a granted read whose data arrives this cycle
    logic        room;         // held + in flight < 2, registered

    logic        cur_valid_n;
    logic        pend_valid_n;
    word_t       cur_word_n;
    word_t       pend_word_n;
    logic        room_n;

    // The read strobe must see the live empty flag and clear, so it is a
    // registered room flag gated by those two inputs. room is 0 in reset,
    // which keeps the strobe low while rst_n is asserted.
    assign fifo_rd_en = room && !fifo_empty && !clear;

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        cur_valid_n  = cur_valid;
        cur_word_n   = cur_word;
        pend_valid_n = pend_valid;
        pend_word_n  = pend_word;

        // Retire cur first; pend moves up in the same cycle so the byte
        // stream has no bubble at a word boundary.
        if (pop) begin
            cur_valid_n  = pend_valid;
            cur_word_n   = pend_word;
            pend_valid_n = 1'b0;
        end

        // A returning word lands in the first free slot after the pop,
        // which keeps order even when it arrives as cur retires.
        if (rd_pending) begin
            if (!cur_valid_n) begin
                cur_valid_n = 1'b1;
                cur_word_n  = fifo_dout;
            end else begin
                pend_valid_n = 1'b1;
                pend_word_n  = fifo_dout;
            end
        end

        // clear wins over both the pop and the returning word.
        if (clear) begin
            cur_valid_n  = 1'b0;
            pend_valid_n = 1'b0;
        end

        room_n = (2'(cur_valid_n) + 2'(pend_valid_n) + 2'(fifo_rd_en)) < 2'd2;
    end

    // NOTE: state registers use non-blocking assignments so all flops update
    // together at the edge regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_valid  <= 1'b0;
            pend_valid <= 1'b0;
            rd_pending <= 1'b0;
            room       <= 1'b0;
        end else begin
            cur_valid  <= cur_valid_n;
            pend_valid <= pend_valid_n;
            rd_pending <= fifo_rd_en;
            room       <= room_n;
        end
    end

    // NOTE: the word storage is not reset; its contents are only ever used
    // behind the valid flags above, which are.
    always_ff @(posedge clk) begin
        cur_word  <= cur_word_n;
        pend_word <= pend_word_n;
    end

endmodule

// File: rtl/bus_unpacker.sv
// Splits 32-bit FIFO words into bytes and presents each byte as its
// {din, d1, d0} fields on a valid/ready interface.
//
// Parameter:
//   LSB_FIRST   1: bytes leave in lane order 0,1,2,3; 0: lane order 3,2,1,0
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        synchronous flush of all buffered data
//   fifo_dout    FIFO read data (standard, non-FWFT FIFO)
//   fifo_empty   FIFO empty flag
//   fifo_rd_en   FIFO read strobe
//   dout_valid   a byte is presented
//   dout_ready   consumer accepts the presented byte
//   din_out      byte bits [7:2]
//   d1_out       byte bit [1]
//   d0_out       byte bit [0]
//   word_last    presented byte is the 4th of its word
module bus_unpacker
    import bus_unpacker_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [WORD_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [DIN_W-1:0]  din_out,
    output logic              d1_out,
    output logic              d0_out,
    output logic              word_last
);

    logic         cur_valid;
    word_t        cur_word;
    byte_idx_t    byte_idx;     // next byte of cur to load into the output
    logic         load;
    logic         load_last;
    byte_fields_t next_fields;

    word_buf2 u_word_buf2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .pop        (load_last),
        .cur_valid  (cur_valid),
        .cur_word   (cur_word)
    );

    // The output register refills when it is empty or its byte is being
    // taken this edge; otherwise it holds, which freezes the byte under
    // backpressure.
    assign load        = cur_valid && (!dout_valid || dout_ready);
    assign load_last   = load && (byte_idx == LAST_IDX);
    assign next_fields = unpack_byte(select_byte(cur_word, byte_idx, LSB_FIRST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_valid <= 1'b0;
            byte_idx   <= '0;
            din_out    <= '0;
            d1_out     <= 1'b0;
            d0_out     <= 1'b0;
            word_last  <= 1'b0;
        end else if (clear) begin
            dout_valid <= 1'b0;
            byte_idx   <= '0;
        end else if (load) begin
            dout_valid <= 1'b1;
            din_out    <= next_fields.din;
            d1_out     <= next_fields.d1;
            d0_out     <= next_fields.d0;
            word_last  <= (byte_idx == LAST_IDX);
            byte_idx   <= byte_idx + 1'b1;   // wraps 3 -> 0 as cur retires
        end else if (dout_ready) begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_unpacker.sv
// Self-checking bench for bus_unpacker: one LSB-first and one MSB-first
// instance share a behavioural FIFO and consumer; a scoreboard derives the
// byte stream from the words the FIFO handed out.
module tb_bus_unpacker;
    import bus_unpacker_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        dout_ready = 1'b1;
    logic [31:0] fifo_dout;
    logic        fifo_empty;

    logic        rd_en_l, valid_l, d1_l, d0_l, last_l;
    logic [5:0]  din_l;
    logic        rd_en_m, valid_m, d1_m, d0_m, last_m;
    logic [5:0]  din_m;
    logic [8:0]  obs_l, obs_m;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] fifo_mem [1024];
    logic [9:0]  wr_ptr = '0;
    logic [9:0]  rd_ptr = '0;

    logic [8:0]  exp_l [$];
    logic [8:0]  exp_m [$];

    assign obs_l      = {last_l, din_l, d1_l, d0_l};
    assign obs_m      = {last_m, din_m, d1_m, d0_m};
    assign fifo_empty = (rd_ptr == wr_ptr);

    bus_unpacker #(.LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(rd_en_l),
        .dout_valid(valid_l), .dout_ready(dout_ready),
        .din_out(din_l), .d1_out(d1_l), .d0_out(d0_l), .word_last(last_l)
    );

    bus_unpacker #(.LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(rd_en_m),
        .dout_valid(valid_m), .dout_ready(dout_ready),
        .din_out(din_m), .d1_out(d1_m), .d0_out(d0_m), .word_last(last_m)
    );

    initial forever #5 clk = ~clk;

    // Standard FIFO: data appears after the edge that grants the read; the
    // bus carries junk otherwise so stale data cannot be mistaken for a word.
    always @(posedge clk) begin
        if (rd_en_l && !fifo_empty) begin
            fifo_dout <= fifo_mem[rd_ptr];
            rd_ptr    <= rd_ptr + 10'd1;
        end else begin
            fifo_dout <= $urandom();
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Byte k of word w in emission order, tagged with its word_last flag.
    function automatic logic [8:0] exp_byte(input logic [31:0] w, input int k,
                                            input bit lsb);
        int          lane;
        logic [31:0] sh;
        lane = lsb ? k : 3 - k;
        sh   = w >> (8 * lane);
        return {k == 3, sh[7:0]};
    endfunction

    task automatic push_word(input logic [31:0] w);
        fifo_mem[wr_ptr] = w;
        wr_ptr           = wr_ptr + 10'd1;
    endtask

    // Monitor: samples 1 ns before each rising edge and predicts that edge.
    initial begin
        bit         hold_l = 1'b0, hold_m = 1'b0;
        logic [8:0] held_l, held_m, e;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                exp_l.delete();
                exp_m.delete();
                hold_l = 1'b0;
                hold_m = 1'b0;
            end else begin
                check("rd_en_while_empty_l", 32'(rd_en_l & fifo_empty), 32'h0);
                check("rd_en_while_empty_m", 32'(rd_en_m & fifo_empty), 32'h0);
                check("rd_en_while_clear", 32'((rd_en_l | rd_en_m) & clear), 32'h0);
                if (hold_l) begin
                    check("hold_valid_l", 32'(valid_l), 32'h1);
                    check("hold_data_l", 32'(obs_l), 32'(held_l));
                end
                if (hold_m) begin
                    check("hold_valid_m", 32'(valid_m), 32'h1);
                    check("hold_data_m", 32'(obs_m), 32'(held_m));
                end
                hold_l = valid_l && !dout_ready && !clear;
                hold_m = valid_m && !dout_ready && !clear;
                held_l = obs_l;
                held_m = obs_m;
                if (valid_l && dout_ready && !clear) begin
                    if (exp_l.size() == 0) check("unexpected_byte_l", 32'(obs_l), 32'h1ff);
                    else begin
                        e = exp_l.pop_front();
                        check("byte_l", 32'(obs_l), 32'(e));
                    end
                end
                if (valid_m && dout_ready && !clear) begin
                    if (exp_m.size() == 0) check("unexpected_byte_m", 32'(obs_m), 32'h1ff);
                    else begin
                        e = exp_m.pop_front();
                        check("byte_m", 32'(obs_m), 32'(e));
                    end
                end
                if (clear) begin
                    exp_l.delete();
                    exp_m.delete();
                end else if (rd_en_l && !fifo_empty) begin
                    for (int k = 0; k < 4; k++) begin
                        exp_l.push_back(exp_byte(fifo_mem[rd_ptr], k, 1'b1));
                        exp_m.push_back(exp_byte(fifo_mem[rd_ptr], k, 1'b0));
                    end
                end
            end
        end
    end

    // Let everything buffered come out; ends on a falling edge.
    task automatic drain();
        bit done = 1'b0;
        dout_ready = 1'b1;
        clear      = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            done = fifo_empty && (exp_l.size() == 0) && (exp_m.size() == 0)
                   && !valid_l && !valid_m;
        end
        check("drain_done", 32'(done), 32'h1);
    endtask

    task automatic wait_valid_negedge();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = valid_l;
        end
        check("wait_valid", 32'(seen), 32'h1);
    endtask

    // Entered on a falling edge with the module idle and ready held high.
    task automatic single_word(input logic [31:0] w);
        push_word(w);
        #1;
        check("sw_rd_en", 32'(rd_en_l), 32'h1);
        @(posedge clk); #1;
        check("sw_lat_e0", 32'({valid_l, valid_m}), 32'h0);
        @(posedge clk); #1;
        check("sw_lat_e1", 32'({valid_l, valid_m}), 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("sw_valid", 32'({valid_l, valid_m}), 32'h3);
            check("sw_byte_l", 32'(obs_l), 32'(exp_byte(w, i, 1'b1)));
            check("sw_byte_m", 32'(obs_m), 32'(exp_byte(w, i, 1'b0)));
        end
        @(posedge clk); #1;
        check("sw_idle", 32'({valid_l, valid_m}), 32'h0);
    endtask

    initial begin
        int cnt;
        int stall_rd;
        bit seen;

        repeat (3) @(negedge clk);
        check("rst_outputs_l", 32'({rd_en_l, valid_l, obs_l}), 32'h0);
        check("rst_outputs_m", 32'({rd_en_m, valid_m, obs_m}), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single words, both byte orders.
        single_word(32'hFFAA5503);
        drain();
        single_word(32'h11223344);
        drain();

        // Streaming: 8 words back to back must give 32 unbroken valid cycles.
        for (int i = 0; i < 8; i++) push_word($urandom());
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #1;
            seen = valid_l;
        end
        cnt = 0;
        while (valid_l && cnt < 40) begin
            cnt++;
            @(posedge clk); #1;
        end
        check("stream_run", 32'(cnt), 32'd32);
        drain();

        // Backpressure during byte 2.
        for (int i = 0; i < 4; i++) push_word($urandom());
        wait_valid_negedge();
        @(negedge clk);
        @(negedge clk);
        dout_ready = 1'b0;
        stall_rd   = 0;
        repeat (5) begin
            @(negedge clk); #1;
            stall_rd += int'(rd_en_l);
        end
        check("stall_rd_en", 32'(stall_rd), 32'h0);
        check("stall_valid", 32'(valid_l), 32'h1);
        dout_ready = 1'b1;
        drain();

        // Clear the cycle after a read: that word is lost, the next starts at byte 0.
        push_word(32'hA1A2A3A4);
        push_word(32'h5B6C7D8E);
        #1;
        check("clr_rd_en", 32'(rd_en_l), 32'h1);
        @(posedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(posedge clk); #1;
        check("clr_valid", 32'({valid_l, valid_m}), 32'h0);
        check("clr_rd_en_gated", 32'(rd_en_l), 32'h0);
        @(negedge clk);
        clear = 1'b0;
        @(posedge clk); #1;
        check("clr_valid_next", 32'({valid_l, valid_m}), 32'h0);
        drain();

        // Asynchronous reset in the middle of a word.
        for (int i = 0; i < 3; i++) push_word($urandom());
        wait_valid_negedge();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_outputs_l", 32'({rd_en_l, valid_l, obs_l}), 32'h0);
        check("arst_outputs_m", 32'({rd_en_m, valid_m, obs_m}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drain();

        // Random traffic, backpressure and occasional clears.
        repeat (600) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) push_word($urandom());
            dout_ready = ($urandom_range(0, 3) != 0);
            clear      = ($urandom_range(0, 60) == 0);
        end
        @(negedge clk);
        clear = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
